rr_decode_arbiter_8: RTL and testbench



---
 rtl/rr_decode_arbiter_8.sv | 109 ++++++++++
 tb/tb_rr_decode_arbiter_8.sv | 136 +++++++++++++
 2 files changed

// File: rtl/rr_decode_arbiter_8.sv
// Round-robin arbiter for 8 requesters sharing one decoded resource.
// Grants carry a bounded tenure and are always separated by one idle cycle.
module rr_decode_arbiter_8 #(
  parameter int CNT_W    = 4,
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [7:0]       gnt_q, gnt_d;
  logic [2:0]       idx_q, idx_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic [2:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  logic             win_found;
  logic [2:0]       win_idx;
  logic [2:0]       cand;

  // First set request at or after ptr, wrapping modulo 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = 3'd0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    idx_d     = idx_q;
    valid_d   = valid_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (en && win_found) begin
          state_d = GRANT;
          gnt_d   = 8'b1 << win_idx;
          idx_d   = win_idx;
          valid_d = 1'b1;
          hold_d  = '0;
        end
      end
      GRANT: begin
        // done beats a request drop, which beats the hold timer.
        if (done || !req[idx_q] || hold_q == HOLD_LAST) begin
          timeout_d = !done && req[idx_q];
          state_d   = IDLE;
          gnt_d     = 8'd0;
          idx_d     = 3'd0;
          valid_d   = 1'b0;
          hold_d    = '0;
          ptr_d     = idx_q + 3'd1;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gnt_q     <= 8'd0;
      idx_q     <= 3'd0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      ptr_q     <= 3'd0;
      hold_q    <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      idx_q     <= idx_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
    end
  end

  assign gnt       = gnt_q;
  assign gnt_idx   = idx_q;
  assign gnt_valid = valid_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter_8.sv
// Directed vector bench for rr_decode_arbiter_8, built with MAX_HOLD=4
// so the hold timer can be exercised in a few cycles.
module tb_rr_decode_arbiter_8;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic [7:0] req = 8'd0;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] expGnt;
    logic [2:0] expIdx;
    logic       expValid;
    logic       expTimeout;
  } vec_t;

  vec_t vecs[$];

  rr_decode_arbiter_8 #(.CNT_W(4), .MAX_HOLD(4)) dut (
    .clk(clk), .reset(reset), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic void add(string n, logic r, logic e, logic [7:0] rq, logic d,
                              logic [7:0] g, logic [2:0] i, logic v, logic t);
    vec_t x;
    x.name = n; x.rst = r; x.en = e; x.req = rq; x.done = d;
    x.expGnt = g; x.expIdx = i; x.expValid = v; x.expTimeout = t;
    vecs.push_back(x);
  endfunction

  task automatic checkOutput(string n, logic [7:0] g, logic [2:0] i, logic v, logic t);
    checks += 4;
    if (gnt !== g) begin
      errors++;
      $display("[TB] FAIL %s gnt got %h want %h", n, gnt, g);
    end
    if (gnt_idx !== i) begin
      errors++;
      $display("[TB] FAIL %s gnt_idx got %0d want %0d", n, gnt_idx, i);
    end
    if (gnt_valid !== v) begin
      errors++;
      $display("[TB] FAIL %s gnt_valid got %b want %b", n, gnt_valid, v);
    end
    if (timeout !== t) begin
      errors++;
      $display("[TB] FAIL %s timeout got %b want %b", n, timeout, t);
    end
  endtask

  task automatic applyStimulus(vec_t x);
    reset = x.rst;
    en    = x.en;
    req   = x.req;
    done  = x.done;
    @(posedge clk);
    #1;
    checkOutput(x.name, x.expGnt, x.expIdx, x.expValid, x.expTimeout);
  endtask

  initial begin
    // Basic grant and release, then ptr=3 prefers idx 3 over idx 2.
    add("t1_grant",   0, 1, 8'h04, 0, 8'h04, 3'd2, 1, 0);
    add("t1_done",    0, 1, 8'h04, 1, 8'h00, 3'd0, 0, 0);
    add("t1_ptr3",    0, 1, 8'h0C, 0, 8'h08, 3'd3, 1, 0);
    add("t1_rel",     0, 1, 8'h0C, 1, 8'h00, 3'd0, 0, 0);
    add("sync_reset", 1, 0, 8'h00, 0, 8'h00, 3'd0, 0, 0);
    // Fairness sweep over all eight requesters plus the wrap back to 0.
    for (int k = 0; k < 9; k++) begin
      add("fair_g", 0, 1, 8'hFF, 0, 8'(1 << (k % 8)), 3'(k % 8), 1, 0);
      add("fair_h", 0, 1, 8'hFF, 0, 8'(1 << (k % 8)), 3'(k % 8), 1, 0);
      add("fair_r", 0, 1, 8'hFF, 1, 8'h00, 3'd0, 0, 0);
    end
    // Hold timer expiry, then regrant to 7 after one gap cycle.
    add("to_g",   0, 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    add("to_h1",  0, 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    add("to_h2",  0, 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    add("to_h3",  0, 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    add("to_rel", 0, 1, 8'h80, 0, 8'h00, 3'd0, 0, 1);
    add("to_reg", 0, 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    // done on the same edge the timer would fire wins, no timeout.
    add("dt_h1",  0, 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    add("dt_h2",  0, 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    add("dt_h3",  0, 1, 8'h80, 0, 8'h80, 3'd7, 1, 0);
    add("dt_rel", 0, 1, 8'h80, 1, 8'h00, 3'd0, 0, 0);
    // Holder drops its request; other request bits do not matter.
    add("rd_g",   0, 1, 8'h20, 0, 8'h20, 3'd5, 1, 0);
    add("rd_oth", 0, 1, 8'h21, 0, 8'h20, 3'd5, 1, 0);
    add("rd_rel", 0, 1, 8'h01, 0, 8'h00, 3'd0, 0, 0);
    // Enable gating; en dropped during a grant has no effect.
    add("en_off1", 0, 0, 8'h11, 0, 8'h00, 3'd0, 0, 0);
    add("en_off2", 0, 0, 8'h11, 0, 8'h00, 3'd0, 0, 0);
    add("en_on",   0, 1, 8'h11, 0, 8'h01, 3'd0, 1, 0);
    add("en_hold1",0, 0, 8'h11, 0, 8'h01, 3'd0, 1, 0);
    add("en_hold2",0, 0, 8'h11, 0, 8'h01, 3'd0, 1, 0);
    add("en_rel",  0, 0, 8'h11, 1, 8'h00, 3'd0, 0, 0);
    add("idle_dn", 0, 0, 8'h00, 1, 8'h00, 3'd0, 0, 0);

    #2 reset = 1'b1;
    #1 checkOutput("reset_async", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) applyStimulus(vecs[i]);

    // Async reset between edges while idx 4 holds (ptr is 1 beforehand).
    applyStimulus('{"ar_g", 1'b0, 1'b1, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0});
    applyStimulus('{"ar_h", 1'b0, 1'b1, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1, 1'b0});
    #2 reset = 1'b1;
    #1 checkOutput("ar_mid", 8'h00, 3'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    applyStimulus('{"ar_ptr0", 1'b0, 1'b1, 8'h82, 1'b0, 8'h02, 3'd1, 1'b1, 1'b0});
    applyStimulus('{"ar_rel",  1'b0, 1'b1, 8'h82, 1'b1, 8'h00, 3'd0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
